// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: word width, the bubble instruction,
// the default reset PC and the IF/ID pipeline register layout.
package riscv_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0 -- architectural no-op used as a pipeline bubble
   localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

   // Default PC after reset; must be word-aligned
   localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

   // IF/ID register contents, shared with decode
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] instr;
      logic            valid;
   } if_id_t;

   // Bubble value written into IF/ID on reset and flush
   function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
      if_id_t b;
      b.pc    = '0;
      b.pc4   = '0;
      b.instr = nop;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage. The memory answers
// combinationally: imem_instr_i is valid in the same cycle as imem_addr_o.
import riscv_pkg::*;

interface fetch_stage_if;

   logic [XLEN-1:0] imem_addr_o;
   logic [XLEN-1:0] imem_instr_i;

   // Fetch side drives the address and receives the instruction
   modport master (output imem_addr_o, input imem_instr_i);

   // Memory side returns the instruction for the presented address
   modport slave  (input imem_addr_o, output imem_instr_i);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold (stall) and clear-to-bubble (flush).
// Priority: reset > clear > hold > load.
import riscv_pkg::*;

module if_id_reg #(
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   hold,
   input  logic   clear,
   input  if_id_t d,
   output if_id_t q
);

   // Pipeline register: bubble on reset/clear, keep on hold, else capture
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of process order.
      if (reset) begin
         q <= if_id_bubble(NOP_INSTR);
      end else if (clear) begin
         q <= if_id_bubble(NOP_INSTR);
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: owns the PC, drives the fetch
// address and loads the IF/ID register. Redirect (flush) beats stall.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/bubble counters.
import riscv_pkg::*;

module fetch_stage #(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic [XLEN-1:0]    redirect_pc_i,
   fetch_stage_if.master      imem,
   output logic [XLEN-1:0]    if_id_pc_o,
   output logic [XLEN-1:0]    if_id_pc4_o,
   output logic [XLEN-1:0]    if_id_instr_o,
   output logic               if_id_valid_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [XLEN-1:0]    fetch_count_o,
   output logic [XLEN-1:0]    bubble_count_o
`endif
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] redirect_aligned;
   if_id_t          if_id_d;
   if_id_t          if_id_q;

   // Word-align the target: the two low bits are simply masked off
   assign redirect_aligned = redirect_pc_i & ~32'h3;
   // Wraps modulo 2^32 at the top of the address space
   assign pc_plus4         = pc + 32'd4;

   // Fetch address comes straight from the PC register
   assign imem.imem_addr_o = pc;

   // Next IF/ID contents on a normal advance
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      if_id_d       = if_id_bubble(NOP_INSTR);
      if_id_d.pc    = pc;
      if_id_d.pc4   = pc_plus4;
      if_id_d.instr = imem.imem_instr_i;
      if_id_d.valid = 1'b1;
   end

   // Program counter: reset, redirect, hold or advance
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (flush_i) begin
         pc <= redirect_aligned;
      end else if (!stall_i) begin
         pc <= pc_plus4;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk   (clk),
      .reset (reset),
      .hold  (stall_i),
      .clear (flush_i),
      .d     (if_id_d),
      .q     (if_id_q)
   );

   assign if_id_pc_o    = if_id_q.pc;
   assign if_id_pc4_o   = if_id_q.pc4;
   assign if_id_instr_o = if_id_q.instr;
   assign if_id_valid_o = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
   // Count normal advances and flush-inserted bubbles; stalls count nothing
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count_o  <= '0;
         bubble_count_o <= '0;
      end else if (flush_i) begin
         bubble_count_o <= bubble_count_o + 32'd1;
      end else if (!stall_i) begin
         fetch_count_o  <= fetch_count_o + 32'd1;
      end
   end
`endif

endmodule
